// File: rtl/wei_buf.sv
// Weight buffer: a load command fills storage from the global buffer, then the
// weight cache reads it with a one-cycle storage latency through a 2-entry output queue.
module wei_buf #(
  parameter int DATA_WIDTH     = 8,
  parameter int WEI_ADDR_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      TOPWBF_CfgVld,
  input  logic [WEI_ADDR_WIDTH:0]   TOPWBF_CfgNum,
  output logic                      WBFTOP_CfgRdy,
  input  logic                      GLBWBF_DatVld,
  input  logic [DATA_WIDTH-1:0]     GLBWBF_Dat,
  output logic                      WBFGLB_DatRdy,
  input  logic                      WCAWBF_AdrVld,
  input  logic [WEI_ADDR_WIDTH-1:0] WCAWBF_Adr,
  output logic                      WBFWCA_AdrRdy,
  output logic                      WBFWCA_DatVld,
  output logic [DATA_WIDTH-1:0]     WBFWCA_Dat,
  input  logic                      WCAWBF_DatRdy,
  output logic                      WBFTOP_AdrErr
);

  localparam int DEPTH = 2 ** WEI_ADDR_WIDTH;
  localparam logic [WEI_ADDR_WIDTH:0] DEPTH_N = {1'b1, {WEI_ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, SERVE} state_e;

  state_e                  state_q, state_d;
  logic [WEI_ADDR_WIDTH:0] num_q, num_d;
  logic [WEI_ADDR_WIDTH:0] wptr_q, wptr_d;
  logic                    err_q, err_d;
  logic                    rd_vld_q, rd_vld_d;
  logic [DATA_WIDTH-1:0]   rd_dat_q, rd_dat_d;
  logic [DATA_WIDTH-1:0]   q_dat_q [2];
  logic [DATA_WIDTH-1:0]   q_dat_d [2];
  logic [1:0]              occ_q, occ_d;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    cfg_rdy, fill_rdy, adr_rdy, dat_vld, pop, push;
  logic                    cfg_fire, fill_fire, adr_fire, adr_oob;
  logic [2:0]              pending;
  logic [WEI_ADDR_WIDTH:0] cfg_num_clamped;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      num_q    <= '0;
      wptr_q   <= '0;
      err_q    <= 1'b0;
      rd_vld_q <= 1'b0;
      rd_dat_q <= '0;
      occ_q    <= '0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      wptr_q   <= wptr_d;
      err_q    <= err_d;
      rd_vld_q <= rd_vld_d;
      rd_dat_q <= rd_dat_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    q_dat_q[0] <= q_dat_d[0];
    q_dat_q[1] <= q_dat_d[1];
    if (!rst && fill_fire) mem[wptr_q[WEI_ADDR_WIDTH-1:0]] <= GLBWBF_Dat;
  end

  always_comb begin
    cfg_num_clamped = (TOPWBF_CfgNum > DEPTH_N) ? DEPTH_N : TOPWBF_CfgNum;
    adr_oob         = {1'b0, WCAWBF_Adr} >= num_q;
    state_d = state_q;
    num_d   = num_q;
    wptr_d  = wptr_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE, SERVE: begin
        if (cfg_fire) begin
          wptr_d = '0;
          if (cfg_num_clamped != '0) begin
            num_d   = cfg_num_clamped;
            state_d = LOAD;
          end else begin
            state_d = SERVE;
          end
        end
      end
      LOAD: begin
        if (fill_fire) begin
          wptr_d = wptr_q + 1'b1;
          if (wptr_q == num_q - 1'b1) state_d = SERVE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A read accepted alongside a new command was checked against the old size, so its error wins.
    if (cfg_fire) err_d = 1'b0;
    if (adr_fire && adr_oob) err_d = 1'b1;
  end

  always_comb begin
    dat_vld   = rd_vld_q | (occ_q != 2'd0);
    pop       = dat_vld & WCAWBF_DatRdy;
    pending   = {1'b0, occ_q} + {2'b0, rd_vld_q} - {2'b0, pop};
    cfg_rdy   = (state_q == IDLE) |
                ((state_q == SERVE) & ~rd_vld_q & (occ_q == 2'd0));
    fill_rdy  = (state_q == LOAD);
    adr_rdy   = (state_q == SERVE) & (pending < 3'd2);
    cfg_fire  = TOPWBF_CfgVld & cfg_rdy;
    fill_fire = GLBWBF_DatVld & fill_rdy;
    adr_fire  = WCAWBF_AdrVld & adr_rdy;
  end

  // In-flight data bypasses the queue when it is empty and consumed immediately.
  always_comb begin
    q_dat_d[0] = q_dat_q[0];
    q_dat_d[1] = q_dat_q[1];
    occ_d      = occ_q;
    push       = rd_vld_q & ~(pop & (occ_q == 2'd0));
    if (pop && occ_q != 2'd0) begin
      q_dat_d[0] = q_dat_q[1];
      occ_d      = occ_q - 2'd1;
    end
    if (push) begin
      q_dat_d[occ_d[0]] = rd_dat_q;
      occ_d             = occ_d + 2'd1;
    end
    rd_vld_d = adr_fire;
    rd_dat_d = rd_dat_q;
    if (adr_fire) rd_dat_d = adr_oob ? '0 : mem[WCAWBF_Adr];
  end

  assign WBFTOP_CfgRdy = cfg_rdy;
  assign WBFGLB_DatRdy = fill_rdy;
  assign WBFWCA_AdrRdy = adr_rdy;
  assign WBFWCA_DatVld = dat_vld;
  assign WBFWCA_Dat    = (occ_q != 2'd0) ? q_dat_q[0] : rd_dat_q;
  assign WBFTOP_AdrErr = err_q;

endmodule

// File: tb/tb_wei_buf.sv
// Bench for wei_buf: a queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations on the returned words.
module tb_wei_buf;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int M_IDLE = 0, M_LOAD = 1, M_SERVE = 2;

  logic clk = 1'b0;
  logic rst;
  logic cfg_vld;  logic [AW:0] cfg_num;  logic cfg_rdy;
  logic glb_vld;  logic [DW-1:0] glb_dat; logic glb_rdy;
  logic adr_vld;  logic [AW-1:0] adr;    logic adr_rdy;
  logic dat_vld;  logic [DW-1:0] dat;    logic dat_rdy;
  logic adr_err;

  wei_buf #(.DATA_WIDTH(DW), .WEI_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .TOPWBF_CfgVld(cfg_vld), .TOPWBF_CfgNum(cfg_num), .WBFTOP_CfgRdy(cfg_rdy),
    .GLBWBF_DatVld(glb_vld), .GLBWBF_Dat(glb_dat), .WBFGLB_DatRdy(glb_rdy),
    .WCAWBF_AdrVld(adr_vld), .WCAWBF_Adr(adr), .WBFWCA_AdrRdy(adr_rdy),
    .WBFWCA_DatVld(dat_vld), .WBFWCA_Dat(dat), .WCAWBF_DatRdy(dat_rdy),
    .WBFTOP_AdrErr(adr_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int            m_state, m_num, m_wcnt;
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] pop_log [$];
  bit            m_err, mv = 1'b0, just_rst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outstanding reads are a queue of expected words.
  always @(negedge clk) begin
    bit pop, afire, cfire, ffire, e_cfgrdy, e_adrrdy;
    int pend, n;
    logic [DW-1:0] rd;
    if (mv) begin
      e_cfgrdy = (m_state == M_IDLE) || (m_state == M_SERVE && exp_q.size() == 0);
      pop      = (exp_q.size() != 0) && dat_rdy;
      pend     = exp_q.size() - (pop ? 1 : 0);
      e_adrrdy = (m_state == M_SERVE) && (pend < 2);
      chk("cfg_rdy", 32'(cfg_rdy), 32'(e_cfgrdy));
      chk("glb_rdy", 32'(glb_rdy), 32'(m_state == M_LOAD));
      chk("adr_rdy", 32'(adr_rdy), 32'(e_adrrdy));
      chk("dat_vld", 32'(dat_vld), 32'(exp_q.size() != 0));
      chk("adr_err", 32'(adr_err), 32'(m_err));
      if (exp_q.size() != 0) chk("dat", 32'(dat), 32'(exp_q[0]));
      if (just_rst) chk("dat_after_rst", 32'(dat), 32'h0);
      just_rst = 1'b0;
    end
    if (rst) begin
      m_state = M_IDLE; m_num = 0; m_wcnt = 0; m_err = 1'b0;
      exp_q.delete();
      mv = 1'b1; just_rst = 1'b1;
    end else if (mv) begin
      afire = adr_vld && e_adrrdy;
      cfire = cfg_vld && e_cfgrdy;
      ffire = glb_vld && (m_state == M_LOAD);
      if (pop) pop_log.push_back(exp_q.pop_front());
      rd = '0;
      if (afire && int'(adr) < m_num) rd = m_mem[adr];
      if (cfire) begin
        n = (int'(cfg_num) > DEPTH) ? DEPTH : int'(cfg_num);
        m_err = 1'b0; m_wcnt = 0;
        if (n > 0) begin m_num = n; m_state = M_LOAD; end
        else m_state = M_SERVE;
      end
      if (afire && int'(adr) >= m_num) m_err = 1'b1;
      if (ffire) begin
        m_mem[m_wcnt] = glb_dat;
        m_wcnt++;
        if (m_wcnt == m_num) m_state = M_SERVE;
      end
      if (afire) exp_q.push_back(rd);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic tmo(input string name);
    n_cmp++; n_bad++;
    $display("FAIL %s: got timeout expected handshake at %0t", name, $time);
  endtask

  // Waits (bounded) for the ready of channel ch, ending one cycle past the transfer.
  task automatic wait_rdy(input int ch, input string name);
    bit ok = 1'b0;
    for (int g = 0; g < 40 && !ok; g++) begin
      @(negedge clk);
      ok = (ch == 0) ? cfg_rdy : (ch == 1) ? glb_rdy : adr_rdy;
      if (!ok) step();
    end
    if (!ok) tmo(name);
    step();
  endtask

  task automatic do_cfg(input int n);
    cfg_vld = 1'b1; cfg_num = (AW+1)'(n);
    wait_rdy(0, "cfg_wait");
    cfg_vld = 1'b0;
  endtask

  task automatic do_fill(input logic [DW-1:0] w);
    glb_vld = 1'b1; glb_dat = w;
    wait_rdy(1, "fill_wait");
  endtask

  task automatic do_read(input int a);
    adr_vld = 1'b1; adr = AW'(a);
    wait_rdy(2, "read_wait");
  endtask

  task automatic drain(input int n);
    for (int g = 0; g < 60 && pop_log.size() < n; g++) step();
    if (pop_log.size() < n) tmo("drain");
  endtask

  initial begin
    int base, acc, a;
    rst = 1'b1; cfg_vld = 1'b0; cfg_num = '0; glb_vld = 1'b0; glb_dat = '0;
    adr_vld = 1'b0; adr = '0; dat_rdy = 1'b1;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cfg_rdy", 32'(cfg_rdy), 32'h1);
    chk("rst_glb_rdy", 32'(glb_rdy), 32'h0);
    chk("rst_adr_rdy", 32'(adr_rdy), 32'h0);
    chk("rst_dat_vld", 32'(dat_vld), 32'h0);
    chk("rst_err", 32'(adr_err), 32'h0);
    chk("rst_dat", 32'(dat), 32'h0);
    step();

    // Fill four words, read 3 then 0.
    do_cfg(4);
    do_fill(8'h11); do_fill(8'h22); do_fill(8'h33); do_fill(8'h44);
    glb_vld = 1'b0;
    do_read(3); do_read(0);
    adr_vld = 1'b0;
    drain(2);
    chk("rd3", 32'(pop_log[0]), 32'h44);
    chk("rd0", 32'(pop_log[1]), 32'h11);
    chk("no_err", 32'(adr_err), 32'h0);

    // Back-to-back reads 0..3.
    base = pop_log.size();
    for (int i = 0; i < 4; i++) do_read(i);
    adr_vld = 1'b0;
    drain(base + 4);
    for (int i = 0; i < 4; i++)
      chk("b2b", 32'(pop_log[base+i]), 32'(8'h11 * (i + 1)));

    // Stall the consumer: only two reads fit in flight.
    base = pop_log.size();
    dat_rdy = 1'b0; adr_vld = 1'b1; acc = 0; a = 0;
    for (int i = 0; i < 5; i++) begin
      adr = AW'(a);
      @(negedge clk);
      if (adr_rdy) begin a++; acc++; end
      if (i == 4) chk("stall_dat", 32'(dat), 32'h11);
      step();
    end
    chk("stall_accepts", 32'(acc), 32'd2);
    adr_vld = 1'b0; dat_rdy = 1'b1;
    drain(base + 2);
    chk("stall_d0", 32'(pop_log[base]), 32'h11);
    chk("stall_d1", 32'(pop_log[base+1]), 32'h22);

    // Out-of-range read, then a zero-length command clears the flag and keeps contents.
    base = pop_log.size();
    do_read(9);
    adr_vld = 1'b0;
    drain(base + 1);
    chk("oob_dat", 32'(pop_log[base]), 32'h0);
    @(negedge clk); chk("oob_err", 32'(adr_err), 32'h1); step();
    do_cfg(0);
    @(negedge clk); chk("err_cleared", 32'(adr_err), 32'h0); step();
    do_read(2);
    adr_vld = 1'b0;
    drain(base + 2);
    chk("retained", 32'(pop_log[base+1]), 32'h33);

    // Reset in the middle of a load.
    do_cfg(4);
    do_fill(8'hA1); do_fill(8'hA2);
    glb_vld = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midload_cfg_rdy", 32'(cfg_rdy), 32'h1);
    chk("midload_glb_rdy", 32'(glb_rdy), 32'h0);
    step();
    base = pop_log.size();
    do_cfg(1); do_fill(8'h5A);
    glb_vld = 1'b0;
    do_read(0);
    adr_vld = 1'b0;
    drain(base + 1);
    chk("reload", 32'(pop_log[base]), 32'h5A);

    // Zero-length command straight from IDLE.
    rst = 1'b1; step(); rst = 1'b0; step();
    do_cfg(0);
    @(negedge clk);
    chk("zero_adr_rdy", 32'(adr_rdy), 32'h1);
    chk("zero_cfg_rdy", 32'(cfg_rdy), 32'h1);
    step();
    base = pop_log.size();
    do_read(0);
    adr_vld = 1'b0;
    drain(base + 1);
    chk("zero_rd", 32'(pop_log[base]), 32'h0);

    // Oversized command is clamped to the full depth.
    do_cfg(20);
    for (int i = 0; i < DEPTH; i++) do_fill(8'(i * 7 + 3));
    glb_vld = 1'b0;
    @(negedge clk); chk("clamp_done", 32'(glb_rdy), 32'h0); step();
    base = pop_log.size();
    do_read(15); do_read(0);
    adr_vld = 1'b0;
    drain(base + 2);
    chk("clamp_rd15", 32'(pop_log[base]), 32'h6C);
    chk("clamp_rd0", 32'(pop_log[base+1]), 32'h03);
    chk("clamp_err", 32'(adr_err), 32'h0);

    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
